// File: rtl/exe_stage.sv
// Execute stage: ALU with iterative shift-add multiply, EXE/MEM output register, upstream stall.
// Optional operand forwarding muxes (fwdA/fwdB) are built when FORWARD_EN is defined.
module exe_stage #(
    parameter int DW         = 32,
    parameter int RW         = 5,
    parameter int MUL_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] readData1In,
    input  logic [DW-1:0] readData2In,
    input  logic [DW-1:0] signExIn,
    input  logic [DW-1:0] PC_In,
    input  logic [3:0]    EXE_In,
    input  logic          regDstIn,
    input  logic [RW-1:0] dest1In,
    input  logic [RW-1:0] dest2In,
    input  logic          M_In,
    input  logic [1:0]    WB_In,
    input  logic          flush,
`ifdef FORWARD_EN
    input  logic [1:0]    fwdA,
    input  logic [1:0]    fwdB,
    input  logic [DW-1:0] memResultIn,
    input  logic [DW-1:0] wbResultIn,
`endif
    output logic          stall,
    output logic [DW-1:0] ALUResultOut,
    output logic [DW-1:0] writeDataOut,
    output logic [RW-1:0] destOut,
    output logic [DW-1:0] PC_Out,
    output logic          M_Out,
    output logic [1:0]    WB_Out
);

    localparam int            CW   = $clog2(MUL_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b100,
        OP_NOR = 3'b101,
        OP_MUL = 3'b110,
        OP_XOR = 3'b111
    } alu_op_e;

    state_e        state_q, state_d;
    logic [DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] res_q, res_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [RW-1:0] dest_q, dest_d;
    logic [DW-1:0] pc_q, pc_d;
    logic          m_q, m_d;
    logic [1:0]    wb_q, wb_d;

    alu_op_e       alu_op;
    logic          is_mul;
    logic [DW-1:0] opnd_a, fwd_b, opnd_b, alu_res;
    logic          load;
    logic [DW-1:0] load_val;

    always_comb begin
`ifdef FORWARD_EN
        case (fwdA)
            2'b01:   opnd_a = wbResultIn;
            2'b10:   opnd_a = memResultIn;
            default: opnd_a = readData1In;
        endcase
        case (fwdB)
            2'b01:   fwd_b = wbResultIn;
            2'b10:   fwd_b = memResultIn;
            default: fwd_b = readData2In;
        endcase
`else
        opnd_a = readData1In;
        fwd_b  = readData2In;
`endif
        opnd_b = EXE_In[3] ? signExIn : fwd_b;
    end

    always_comb begin
        alu_op = alu_op_e'(EXE_In[2:0]);
        is_mul = (alu_op == OP_MUL);
        case (alu_op)
            OP_ADD:  alu_res = opnd_a + opnd_b;
            OP_SUB:  alu_res = opnd_a - opnd_b;
            OP_AND:  alu_res = opnd_a & opnd_b;
            OP_OR:   alu_res = opnd_a | opnd_b;
            OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(opnd_a) < $signed(opnd_b))};
            OP_NOR:  alu_res = ~(opnd_a | opnd_b);
            OP_XOR:  alu_res = opnd_a ^ opnd_b;
            default: alu_res = '0;
        endcase
    end

    // Gated by rst so stall reads 0 while reset is held even if a MUL is presented.
    assign stall = rst && ((state_q == BUSY) || (state_q == IDLE && is_mul));

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        load     = 1'b0;
        load_val = '0;
        res_d    = '0;
        wdata_d  = '0;
        dest_d   = '0;
        pc_d     = '0;
        m_d      = 1'b0;
        wb_d     = '0;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_mul) begin
                        state_d  = BUSY;
                        mcand_d  = opnd_a;
                        mplier_d = opnd_b;
                        acc_d    = '0;
                        count_d  = '0;
                    end else begin
                        load     = 1'b1;
                        load_val = alu_res;
                    end
                end
                BUSY: begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (count_q == LAST) state_d = DONE;
                end
                DONE: begin
                    state_d  = IDLE;
                    load     = 1'b1;
                    load_val = acc_q;
                end
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            res_d   = load_val;
            wdata_d = fwd_b;
            dest_d  = regDstIn ? dest2In : dest1In;
            pc_d    = PC_In;
            m_d     = M_In;
            wb_d    = WB_In;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            res_q    <= '0;
            wdata_q  <= '0;
            dest_q   <= '0;
            pc_q     <= '0;
            m_q      <= 1'b0;
            wb_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            res_q    <= res_d;
            wdata_q  <= wdata_d;
            dest_q   <= dest_d;
            pc_q     <= pc_d;
            m_q      <= m_d;
            wb_q     <= wb_d;
        end
    end

    assign ALUResultOut = res_q;
    assign writeDataOut = wdata_q;
    assign destOut      = dest_q;
    assign PC_Out       = pc_q;
    assign M_Out        = m_q;
    assign WB_Out       = wb_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized traffic against a behavioural model.
module tb_exe_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] readData1In, readData2In, signExIn, PC_In;
    logic [3:0]    EXE_In;
    logic          regDstIn;
    logic [RW-1:0] dest1In, dest2In;
    logic          M_In;
    logic [1:0]    WB_In;
    logic          flush;
    logic [1:0]    fwdA, fwdB;
    logic [DW-1:0] memResultIn, wbResultIn;
    logic          stall;
    logic [DW-1:0] ALUResultOut, writeDataOut, PC_Out;
    logic [RW-1:0] destOut;
    logic          M_Out;
    logic [1:0]    WB_Out;

    always #5 clk = ~clk;

    exe_stage #(.DW(DW), .RW(RW), .MUL_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .readData1In(readData1In), .readData2In(readData2In),
        .signExIn(signExIn), .PC_In(PC_In), .EXE_In(EXE_In),
        .regDstIn(regDstIn), .dest1In(dest1In), .dest2In(dest2In),
        .M_In(M_In), .WB_In(WB_In), .flush(flush),
`ifdef FORWARD_EN
        .fwdA(fwdA), .fwdB(fwdB), .memResultIn(memResultIn), .wbResultIn(wbResultIn),
`endif
        .stall(stall), .ALUResultOut(ALUResultOut), .writeDataOut(writeDataOut),
        .destOut(destOut), .PC_Out(PC_Out), .M_Out(M_Out), .WB_Out(WB_Out)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] fwd_pick(input logic [1:0] s, input logic [31:0] idv);
`ifdef FORWARD_EN
        if (s == 2'b01) return wbResultIn;
        if (s == 2'b10) return memResultIn;
`endif
        return idv;
    endfunction

    function automatic logic [31:0] m_opa();
        return fwd_pick(fwdA, readData1In);
    endfunction

    function automatic logic [31:0] m_bstore();
        return fwd_pick(fwdB, readData2In);
    endfunction

    function automatic logic [31:0] m_opb();
        return EXE_In[3] ? signExIn : m_bstore();
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: return ~(a | b);
            3'd6: return a * b;
            default: return a ^ b;
        endcase
    endfunction

    int          busy_left = 0;
    bit          done_pend = 0;
    logic [31:0] ma, mb;
    logic [31:0] exp_alu, exp_wd, exp_pc;
    logic [4:0]  exp_dest;
    logic        exp_m;
    logic [1:0]  exp_wb;
    bit          m_stall = 0;
    bit          chk_en  = 0;

    task automatic model_load(input logic [31:0] r);
        exp_alu  = r;
        exp_wd   = m_bstore();
        exp_dest = regDstIn ? dest2In : dest1In;
        exp_pc   = PC_In;
        exp_m    = M_In;
        exp_wb   = WB_In;
    endtask

    always @(posedge clk or negedge rst) begin
        exp_alu = '0; exp_wd = '0; exp_pc = '0; exp_dest = '0; exp_m = 1'b0; exp_wb = '0;
        if (!rst) begin
            busy_left = 0;
            done_pend = 0;
        end else if (flush) begin
            busy_left = 0;
            done_pend = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) done_pend = 1;
        end else if (done_pend) begin
            done_pend = 0;
            model_load(ma * mb);
        end else if (EXE_In[2:0] == 3'b110) begin
            ma = m_opa();
            mb = m_opb();
            busy_left = 32;
        end else begin
            model_load(alu(EXE_In[2:0], m_opa(), m_opb()));
        end
    end

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        m_stall = rst && ((busy_left > 0) || (!done_pend && EXE_In[2:0] == 3'b110));
        if (rst && chk_en) begin
            chk("stall",    32'(stall),        32'(m_stall));
            chk("alu",      ALUResultOut,      exp_alu);
            chk("wdata",    writeDataOut,      exp_wd);
            chk("dest",     32'(destOut),      32'(exp_dest));
            chk("pc",       PC_Out,            exp_pc);
            chk("m",        32'(M_Out),        32'(exp_m));
            chk("wb",       32'(WB_Out),       32'(exp_wb));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_nop();
        readData1In = '0; readData2In = '0; signExIn = '0; PC_In = '0;
        EXE_In = 4'b0000; regDstIn = 1'b0; dest1In = '0; dest2In = '0;
        M_In = 1'b0; WB_In = 2'b00; fwdA = 2'b00; fwdB = 2'b00;
        memResultIn = '0; wbResultIn = '0;
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] exe,
                          input logic rd, input logic [4:0] d1, input logic [4:0] d2, input logic [1:0] wb);
        set_nop();
        readData1In = a; readData2In = b; signExIn = b; EXE_In = exe;
        regDstIn = rd; dest1In = d1; dest2In = d2; WB_In = wb; PC_In = 32'h0000_0040;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_inputs();
        readData1In = pick(); readData2In = pick(); signExIn = pick(); PC_In = $urandom;
        EXE_In = 4'($urandom_range(0, 15));
        regDstIn = 1'($urandom_range(0, 1));
        dest1In = 5'($urandom_range(0, 31)); dest2In = 5'($urandom_range(0, 31));
        M_In = 1'($urandom_range(0, 1)); WB_In = 2'($urandom_range(0, 3));
        fwdA = 2'($urandom_range(0, 3)); fwdB = 2'($urandom_range(0, 3));
        memResultIn = pick(); wbResultIn = pick();
    endtask

    task automatic wait_mul(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (stall) n++;
            else break;
        end
    endtask

    int n_stall;
    int hits;

    initial begin
        set_nop();
        flush = 1'b0;
        rst   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_alu", ALUResultOut, 32'd0);
        chk("rst_wb", 32'(WB_Out), 32'd0);
        #1 rst = 1'b1;
        chk_en = 1;

        // ADD immediate
        @(posedge clk); #1;
        set_op(32'd5, 32'd7, 4'b1000, 1'b0, 5'd9, 5'd0, 2'b10);
        readData2In = 32'd99;
        #1 chk("add_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("add_res", ALUResultOut, 32'd12);
        chk("add_dest", 32'(destOut), 32'd9);
        chk("add_wb", 32'(WB_Out), 32'd2);
        chk("add_wdata", writeDataOut, 32'd99);

        // SLT signed both ways
        set_op(32'hFFFF_FFFF, 32'd1, 4'b0100, 1'b0, 5'd1, 5'd0, 2'b10);
        @(posedge clk); #1;
        chk("slt_neg", ALUResultOut, 32'd1);
        set_op(32'd1, 32'hFFFF_FFFF, 4'b0100, 1'b0, 5'd1, 5'd0, 2'b10);
        @(posedge clk); #1;
        chk("slt_pos", ALUResultOut, 32'd0);

        // MUL 6*7 then back-to-back MUL that wraps to 0
        set_op(32'd6, 32'd7, 4'b0110, 1'b1, 5'd0, 5'd3, 2'b10);
        wait_mul(n_stall);
        chk("mul_stall_len", 32'(n_stall), 32'd33);
        @(posedge clk); #1;
        chk("mul_res", ALUResultOut, 32'd42);
        chk("mul_dest", 32'(destOut), 32'd3);
        set_op(32'h0001_0000, 32'h0001_0000, 4'b0110, 1'b1, 5'd0, 5'd4, 2'b10);
        wait_mul(n_stall);
        chk("mul2_stall_len", 32'(n_stall), 32'd33);
        @(posedge clk); #1;
        chk("mul2_res", ALUResultOut, 32'd0);
        chk("mul2_wb", 32'(WB_Out), 32'd2);
        chk("mul2_dest", 32'(destOut), 32'd4);

        // Reset mid-multiply at count 10
        set_op(32'd3, 32'd5, 4'b0110, 1'b0, 5'd7, 5'd0, 2'b10);
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 chk("pre_rst_stall", 32'(stall), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_alu", ALUResultOut, 32'd0);
        chk("async_rst_m", 32'(M_Out), 32'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        set_op(32'd1, 32'd1, 4'b0000, 1'b0, 5'd2, 5'd0, 2'b10);
        #1 chk("post_rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_add", ALUResultOut, 32'd2);

        // Flush during BUSY at count 5
        set_op(32'd1234, 32'd5678, 4'b0110, 1'b0, 5'd6, 5'd0, 2'b11);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        set_nop();
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_wb", 32'(WB_Out), 32'd0);
        chk("flush_m", 32'(M_Out), 32'd0);
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ALUResultOut == 32'd7006652) hits++;
        end
        chk("flush_no_product", 32'(hits), 32'd0);

`ifdef FORWARD_EN
        set_op(32'd0, 32'd1, 4'b1000, 1'b0, 5'd1, 5'd0, 2'b10);
        fwdA = 2'b10; memResultIn = 32'd100;
        @(posedge clk); #1;
        chk("fwd_a_mem", ALUResultOut, 32'd101);
        set_op(32'd4, 32'd8, 4'b1000, 1'b0, 5'd1, 5'd0, 2'b00);
        M_In = 1'b1; fwdB = 2'b01; wbResultIn = 32'd55;
        @(posedge clk); #1;
        chk("fwd_b_store", writeDataOut, 32'd55);
        set_nop();
`endif

        // Randomized traffic; inputs hold while the previous cycle stalled, as ID/EXE would.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (flush) begin
                flush = 1'b0;
                rand_inputs();
            end else if (!m_stall) begin
                rand_inputs();
            end
            if ($urandom_range(0, 39) == 0) flush = 1'b1;
        end
        @(posedge clk); #1;
        flush = 1'b0;
        set_nop();
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
